sequence_detector_1101_moore: RTL and testbench
===============================================

SEQUENCE_DETECTOR_1101_MOORE -- requirements
Module: sequence_detector_1101_moore

Interface
REQ-001 Parameter: OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping detection.
REQ-002 Port: clk, input, 1, the single clock; all state changes SHALL occur on its rising edge.
REQ-003 Port: rst, input, 1, reset; asynchronous, active-high.
REQ-004 Port: x, input, 1, serial data bit, sampled on each rising clk edge.
REQ-005 Port: y, output, 1, detect flag; high for exactly one cycle per detected "1101".

Function
REQ-006 The block SHALL be a Moore FSM: y depends only on the state register, never directly on x.
REQ-007 The FSM SHALL have five states:
- S0: idle / no prefix matched.
- S1: "1" matched.
- S2: "11" matched.
- S3: "110" matched.
- S4: "1101" detected.
REQ-008 Transitions out of S0 SHALL be x=1 -> S1; x=0 -> S0.
REQ-009 Transitions out of S1 SHALL be x=1 -> S2; x=0 -> S0.
REQ-010 Transitions out of S2 SHALL be x=1 -> S2 (longest "11" suffix is kept); x=0 -> S3.
REQ-011 Transitions out of S3 SHALL be x=1 -> S4; x=0 -> S0.
REQ-012 With OVERLAP=1, S4 SHALL go x=1 -> S2 (trailing "1" plus new "1"); x=0 -> S0.
REQ-013 With OVERLAP=0, S4 SHALL go x=1 -> S1; x=0 -> S0.
REQ-014 y SHALL be 1 if and only if the state is S4; it SHALL be decoded from the state register alone, so it is glitch-free.
REQ-015 Latency: y SHALL rise in the cycle after the edge that samples the final "1" of "1101", and SHALL stay high for exactly one clock period unless S4 is re-entered.
REQ-016 Back-to-back detections SHALL be possible with OVERLAP=1 at a minimum spacing of 3 cycles ("1101101" yields two pulses).
REQ-017 Any unreachable or illegal state encoding SHALL return to S0 on the next edge, with y=0.

Reset
REQ-018 While rst=1, the state SHALL be S0 and y=0 immediately, independent of clk.
REQ-019 Asserting rst mid-sequence SHALL discard any partial match; detection restarts from S0 after release.
REQ-020 Deassertion of rst SHALL take effect at the next rising clk edge; the first x sample is taken at that edge.

Structure
REQ-021 State encodings (S0..S4, 3-bit binary) SHALL be defined as named constants in a shared package.
REQ-022 The design SHALL be organised as three parts:
- a state register with async reset;
- a combinational next-state block;
- a combinational output decode.
REQ-023 No sub-module is required; the block SHALL be a single flat module.

Verification
REQ-024 Reset check: hold rst=1 for 1 cycle with x=0 -> y=0 and state=S0; assert rst asynchronously between edges -> y drops at once.
REQ-025 Overlap stream: with OVERLAP=1, release rst, then drive x=1,1,0,1,1,0,1 one bit per cycle -> y=1 only in the cycle after the 4th bit and the cycle after the 7th bit, 0 elsewhere.
REQ-026 Non-overlap: with OVERLAP=0, drive x=1,1,0,1,1,0,1 -> one pulse after bit 4; sequence "1101101" -> one pulse with OVERLAP=0, two with OVERLAP=1.
REQ-027 Near-misses: drive x=1,0,0,1,1,1,1,0,0 -> y stays 0 throughout.
REQ-028 Reset mid-match: drive x=1,1,0, pulse rst, then x=1 -> y stays 0; next full "1101" -> one pulse.
REQ-029 Moore property: toggle x between clock edges while in S4 -> y does not change until the next edge.

Source files
------------

// File: rtl/sequence_detector_1101_moore_pkg.sv
// rtl/sequence_detector_1101_moore_pkg.sv - shared state encodings for the 1101 Moore detector
//
// Purpose: named 3-bit binary state constants shared by the detector and its bench.
// Ports:   none (package).
package sequence_detector_1101_moore_pkg;

  localparam int STATE_W = 3;

  // Each state records the longest prefix of "1101" that the recent input ends with.
  localparam logic [STATE_W-1:0] S0 = 3'd0;  // no prefix matched
  localparam logic [STATE_W-1:0] S1 = 3'd1;  // "1"
  localparam logic [STATE_W-1:0] S2 = 3'd2;  // "11"
  localparam logic [STATE_W-1:0] S3 = 3'd3;  // "110"
  localparam logic [STATE_W-1:0] S4 = 3'd4;  // "1101" detected

  function automatic logic is_detect_state(input logic [STATE_W-1:0] s);
    return (s == S4);
  endfunction

endpackage

// File: rtl/sequence_detector_1101_moore.sv
// rtl/sequence_detector_1101_moore.sv - Moore FSM detecting the serial pattern "1101"
//
// Purpose: raises y for one cycle in the cycle after the final '1' of "1101" is sampled.
//          OVERLAP=1 lets the trailing '1' of a match start the next one; OVERLAP=0 does not.
// Ports:
//   clk - single clock, all state changes on its rising edge
//   rst - asynchronous active-high reset, forces S0 / y=0 immediately
//   x   - serial data bit, sampled on each rising clk edge
//   y   - detect flag, decoded from the state register only
module sequence_detector_1101_moore
  import sequence_detector_1101_moore_pkg::*;
#(
  parameter int OVERLAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = x ? S1 : S0;
      S1: state_d = x ? S2 : S0;
      // A run of ones keeps the "11" suffix alive.
      S2: state_d = x ? S2 : S3;
      S3: state_d = x ? S4 : S0;
      // After a match the last '1' plus a new '1' forms "11" when overlapping;
      // without overlap the match is consumed and only the new '1' counts.
      S4: begin
        if (x) begin
          state_d = (OVERLAP != 0) ? S2 : S1;
        end else begin
          state_d = S0;
        end
      end
      // Unused encodings recover to idle.
      default: state_d = S0;
    endcase
  end

  // Output decode from the register alone keeps y glitch-free and independent of x.
  assign y = is_detect_state(state_q);

endmodule

// File: tb/tb_sequence_detector_1101_moore.sv
// tb/tb_sequence_detector_1101_moore.sv - scoreboard bench for the 1101 Moore detector
module tb_sequence_detector_1101_moore;
  import sequence_detector_1101_moore_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic y_ov;
  logic y_no;

  always #5 clk = ~clk;

  sequence_detector_1101_moore #(.OVERLAP(1)) dut_ov (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y_ov)
  );

  sequence_detector_1101_moore #(.OVERLAP(0)) dut_no (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y_no)
  );

  int total = 0;
  int bad   = 0;
  int cnt_ov = 0;
  int cnt_no = 0;

  bit q_ov[$];
  bit q_no[$];
  bit h_ov[$];
  bit h_no[$];
  bit last_ov = 1'b0;
  bit last_no = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a detection happens when the bits seen so far end in 1,1,0,1.
  function automatic bit ends_1101(input bit h[$]);
    int n;
    n = h.size();
    if (n < 4) return 1'b0;
    return (h[n-4] == 1'b1) && (h[n-3] == 1'b1) && (h[n-2] == 1'b0) && (h[n-1] == 1'b1);
  endfunction

  task automatic model_reset();
    h_ov.delete();
    h_no.delete();
    last_ov = 1'b0;
    last_no = 1'b0;
  endtask

  // Drive one bit; the expected y after the sampling edge goes to the scoreboard.
  task automatic step(input bit b);
    @(negedge clk);
    x = b;
    h_ov.push_back(b);
    if (h_ov.size() > 4) void'(h_ov.pop_front());
    last_ov = ends_1101(h_ov);
    h_no.push_back(b);
    last_no = ends_1101(h_no);
    // Non-overlapping: bits of a match cannot be reused.
    if (last_no) h_no.delete();
    q_ov.push_back(last_ov);
    q_no.push_back(last_no);
  endtask

  task automatic drive_seq(input bit [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) step(bits[i]);
  endtask

  // Assert reset between edges, confirm y drops at once, release before the next edge.
  task automatic pulse_reset(input string name);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({name, "_y_ov"}, y_ov, 1'b0);
    check({name, "_y_no"}, y_no, 1'b0);
    check({name, "_state"}, (dut_ov.state_q == S0), 1'b1);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    @(posedge clk);
    #3;
  endtask

  // Monitor: compare every sampled output against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q_ov.size() > 0) begin
        check("y_ov", y_ov, q_ov.pop_front());
        if (y_ov === 1'b1) cnt_ov++;
      end
      if (q_no.size() > 0) begin
        check("y_no", y_no, q_no.pop_front());
        if (y_no === 1'b1) cnt_no++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0_ov;
    int c0_no;

    // Reset held through an edge with x=0.
    @(posedge clk);
    @(negedge clk);
    check("reset_y_ov", y_ov, 1'b0);
    check("reset_y_no", y_no, 1'b0);
    check("reset_state_ov", (dut_ov.state_q == S0), 1'b1);
    check("reset_state_no", (dut_no.state_q == S0), 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // "1101101": two pulses overlapping, one non-overlapping.
    c0_ov = cnt_ov;
    c0_no = cnt_no;
    drive_seq(16'b1101101, 7);
    drain();
    check_int("overlap_pulses", cnt_ov - c0_ov, 2);
    check_int("nonoverlap_pulses", cnt_no - c0_no, 1);

    // Moore property: x toggling while in S4 does not move y.
    pulse_reset("pre_moore");
    drive_seq(16'b1101, 4);
    @(posedge clk);
    #3;
    check("s4_y_ov_before", y_ov, 1'b1);
    x = ~x;
    #1;
    check("moore_y_ov", y_ov, last_ov);
    check("moore_y_no", y_no, last_no);
    x = ~x;
    #0;
    // Asynchronous reset while y is high.
    rst = 1'b1;
    #1;
    check("async_rst_y_ov", y_ov, 1'b0);
    check("async_rst_y_no", y_no, 1'b0);
    rst = 1'b0;
    model_reset();

    // Near misses never detect.
    c0_ov = cnt_ov;
    drive_seq(16'b100111100, 9);
    drain();
    check_int("near_miss_pulses", cnt_ov - c0_ov, 0);

    // Reset mid-match discards "110".
    pulse_reset("pre_mid");
    drive_seq(16'b110, 3);
    pulse_reset("mid_match");
    c0_ov = cnt_ov;
    step(1'b1);
    drain();
    check_int("after_mid_rst_pulses", cnt_ov - c0_ov, 0);
    pulse_reset("pre_full");
    c0_ov = cnt_ov;
    c0_no = cnt_no;
    drive_seq(16'b1101, 4);
    drain();
    check_int("full_after_rst_ov", cnt_ov - c0_ov, 1);
    check_int("full_after_rst_no", cnt_no - c0_no, 1);

    // Randomized stream, biased toward ones, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset("rand_rst");
      step($urandom_range(0, 2) != 0);
    end
    drain();
    drain();
    check_int("queue_ov_empty", q_ov.size(), 0);
    check_int("queue_no_empty", q_no.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
